// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: opcode constants and state type shared by the fetch sequencer
package fetch_seq_pkg;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 9;
  localparam logic [6:0] LRLI_OP = 7'b1000010;
  localparam logic [6:0] CALL_OP = 7'b1001110;
  localparam logic [6:0] RET_OP = 7'b1001111;
  typedef enum logic {FETCH, EXT} state_t;
endpackage

// File: rtl/fetch_sequencer_return_stack.sv
// return_stack: small LIFO of return addresses; pushes when full are dropped, pops when empty read zero
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] count;
  logic [AW-1:0] top;
  assign top = count[AW-1:0] - AW'(1);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[top];
  // entry storage needs no reset; only the occupancy count defines validity
  always_ff @(posedge clk)
    if (push && !full) mem[count[AW-1:0]] <= din;
  // occupancy tracking; overflowing pushes and underflowing pops leave it unchanged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (push && !full) count <= count + (AW+1)'(1);
    else if (pop && !empty) count <= count - (AW+1)'(1);
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/ROM fetch with LRLI assembly, local CALL/RET and execute redirect
module fetch_sequencer #(
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  pc,
  input  logic [15:0] rom_data,
  output logic [15:0] ir_out,
  output logic [15:0] ext_out,
  output logic [7:0]  ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        ras_err
);
  import fetch_seq_pkg::*;
  state_t state;
  logic fe, push, pop, full, empty;
  logic [6:0] opc;
  logic [7:0] pc_inc, ras_top;
  assign fe = !ir_valid || ir_ready;
  assign opc = rom_data[OPC_MSB:OPC_LSB];
  assign pc_inc = pc + 8'd1;
  assign push = state == FETCH && fe && !redirect_valid && opc == CALL_OP;
  assign pop = state == FETCH && fe && !redirect_valid && opc == RET_OP;
  return_stack #(.DEPTH(RAS_DEPTH), .WIDTH(8)) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ras_top),
    .full  (full),
    .empty (empty)
  );
  // fetch state machine: redirect wins, EXT completes an LRLI, FETCH captures when the slot frees
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      pc <= '0;
      ir_out <= '0;
      ext_out <= '0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
      ras_err <= 1'b0;
    end else begin
      ras_err <= ras_err || (push && full) || (pop && empty);
      if (redirect_valid) begin
        pc <= redirect_pc;
        ir_valid <= 1'b0;
        state <= FETCH;
      end else if (state == EXT) begin
        ext_out <= rom_data;
        pc <= pc_inc;
        ir_valid <= 1'b1;
        state <= FETCH;
      end else if (fe) begin
        ir_out <= rom_data;
        ir_pc <= pc;
        ext_out <= '0;
        pc <= opc == CALL_OP ? rom_data[7:0] : opc == RET_OP ? ras_top : pc_inc;
        ir_valid <= opc != LRLI_OP;
        state <= opc == LRLI_OP ? EXT : FETCH;
      end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch, LRLI, CALL/RET, stall, redirect and stack errors
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] pc, ir_pc, redirect_pc;
  logic [15:0] rom_data, ir_out, ext_out;
  logic ir_valid, ir_ready, redirect_valid, ras_err;
  logic [15:0] rom [256];
  int errors = 0;
  int checks = 0;

  fetch_sequencer #(.RAS_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .rom_data       (rom_data),
    .ir_out         (ir_out),
    .ext_out        (ext_out),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ras_err        (ras_err)
  );

  assign rom_data = rom[pc];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redir(input logic [7:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    tick;
    redirect_valid = 1'b0;
  endtask

  initial begin
    foreach (rom[i]) rom[i] = 16'h0000;
    rom[8'h00] = 16'h1000;
    rom[8'h01] = 16'h1001;
    rom[8'h02] = 16'h1002;
    rom[8'h03] = 16'h1003;
    rom[8'h04] = 16'h9E00;
    rom[8'h10] = 16'h9E00;
    rom[8'h16] = 16'h844A;
    rom[8'h17] = 16'h0001;
    rom[8'h18] = 16'h1018;
    rom[8'h1E] = 16'h9C04;
    rom[8'h1F] = 16'h2345;
    rom[8'h20] = 16'h3333;
    rom[8'h30] = 16'h844A;
    rom[8'h31] = 16'hBEEF;
    rom[8'h40] = 16'h9E00;
    rom[8'h50] = 16'h9C60;
    rom[8'h60] = 16'h9C70;
    rom[8'h70] = 16'h9C80;
    rom[8'h80] = 16'h9C90;
    rom[8'h90] = 16'h9CA0;
    rom[8'hA0] = 16'h9E00;
    rom[8'h81] = 16'h9E00;
    rom[8'h71] = 16'h9E00;
    rom[8'h61] = 16'h9E00;
    rom[8'hFF] = 16'h9C10;
    ir_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 16'h00);
    chk("rst_valid", ir_valid, 16'h0);
    chk("rst_err", ras_err, 16'h0);
    chk("rst_ir", ir_out, 16'h0000);
    chk("rst_ext", ext_out, 16'h0000);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("seq_pc", pc, 16'(k));
      chk("seq_irpc", ir_pc, 16'(k - 1));
      chk("seq_ir", ir_out, 16'h1000 + 16'(k - 1));
      chk("seq_valid", ir_valid, 16'h1);
      chk("seq_ext", ext_out, 16'h0000);
    end
    redir(8'h16);
    chk("lrli_redir_pc", pc, 16'h16);
    chk("lrli_redir_valid", ir_valid, 16'h0);
    tick;
    chk("lrli_bubble_valid", ir_valid, 16'h0);
    chk("lrli_bubble_pc", pc, 16'h17);
    tick;
    chk("lrli_valid", ir_valid, 16'h1);
    chk("lrli_ir", ir_out, 16'b1000010001001010);
    chk("lrli_ext", ext_out, 16'h0001);
    chk("lrli_irpc", ir_pc, 16'h16);
    chk("lrli_next_pc", pc, 16'h18);
    tick;
    chk("after_lrli_ir", ir_out, 16'h1018);
    chk("after_lrli_ext", ext_out, 16'h0000);
    redir(8'h1E);
    chk("call_redir_pc", pc, 16'h1E);
    tick;
    chk("call_pc", pc, 16'h04);
    chk("call_ir", ir_out, 16'h9C04);
    chk("call_irpc", ir_pc, 16'h1E);
    tick;
    chk("ret_pc", pc, 16'h1F);
    chk("ret_irpc", ir_pc, 16'h04);
    chk("ret_err", ras_err, 16'h0);
    chk("ret_empty", dut.u_ras.empty, 16'h1);
    tick;
    chk("pre_stall_pc", pc, 16'h20);
    ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("stall_ir", ir_out, 16'h2345);
      chk("stall_irpc", ir_pc, 16'h1F);
      chk("stall_pc", pc, 16'h20);
      chk("stall_valid", ir_valid, 16'h1);
    end
    ir_ready = 1'b1;
    tick;
    chk("unstall_pc", pc, 16'h21);
    chk("unstall_irpc", ir_pc, 16'h20);
    redir(8'h30);
    tick;
    chk("ext_enter_pc", pc, 16'h31);
    chk("ext_enter_valid", ir_valid, 16'h0);
    redir(8'h20);
    chk("ext_redir_pc", pc, 16'h20);
    chk("ext_redir_valid", ir_valid, 16'h0);
    tick;
    chk("ext_squash_ir", ir_out, 16'h3333);
    chk("ext_squash_ext", ext_out, 16'h0000);
    chk("ext_squash_irpc", ir_pc, 16'h20);
    chk("ext_squash_valid", ir_valid, 16'h1);
    redir(8'h40);
    tick;
    chk("uflow_pc", pc, 16'h00);
    chk("uflow_err", ras_err, 16'h1);
    chk("uflow_irpc", ir_pc, 16'h40);
    ir_ready = 1'b0;
    tick;
    chk("stall_err_sticky", ras_err, 16'h1);
    rst_n = 1'b0;
    #1;
    chk("midstall_rst_err", ras_err, 16'h0);
    chk("midstall_rst_pc", pc, 16'h00);
    chk("midstall_rst_valid", ir_valid, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ir_ready = 1'b1;
    redir(8'h50);
    tick;
    chk("nest1_pc", pc, 16'h60);
    tick;
    chk("nest2_pc", pc, 16'h70);
    tick;
    chk("nest3_pc", pc, 16'h80);
    tick;
    chk("nest4_pc", pc, 16'h90);
    chk("nest4_err", ras_err, 16'h0);
    tick;
    chk("nest5_pc", pc, 16'hA0);
    chk("oflow_err", ras_err, 16'h1);
    tick;
    chk("unwind1_pc", pc, 16'h81);
    tick;
    chk("unwind2_pc", pc, 16'h71);
    tick;
    chk("unwind3_pc", pc, 16'h61);
    tick;
    chk("unwind4_pc", pc, 16'h51);
    chk("unwind_err_sticky", ras_err, 16'h1);
    redir(8'hFF);
    tick;
    chk("wrap_call_pc", pc, 16'h10);
    chk("wrap_call_irpc", ir_pc, 16'hFF);
    tick;
    chk("wrap_ret_pc", pc, 16'h00);
    chk("wrap_err_sticky", ras_err, 16'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
